fb_write_ctrl: RTL and testbench
================================

// Module: fb_write_ctrl
// PURPOSE
//  Upstream write-side stage of Frame_Buffer. Takes the RGB pixel stream from RAW2RGB
//  with its frame/line/data valids, and drives the framebuffer write port: iX, iY,
//  frame_write_enable and iRed/iGreen/iBlue. Tracks frame/line position, clips to the
//  active window and reports frame completion and stream errors.
// PARAMETERS
//  H_ACTIVE   640  pixels per line written to the framebuffer
//  V_ACTIVE   480  lines per frame written to the framebuffer
//  CNT_W      16   width of the frame counter
// PORTS
//  clk          in   1      pixel clock (same clock as Frame_Buffer)
//  reset        in   1      synchronous, active-low reset
//  in_fval      in   1      frame valid from RAW2RGB
//  in_lval      in   1      line valid
//  in_dval      in   1      pixel valid (qualifies in_red/green/blue)
//  in_red       in   8      red component; in_green, in_blue identical (8 each)
//  oRed/oGreen/oBlue out 8  pixel to Frame_Buffer iRed/iGreen/iBlue
//  oX           out  10     write X -> Frame_Buffer iX
//  oY           out  10     write Y -> Frame_Buffer iY
//  oWE          out  1      -> frame_write_enable
//  oFrameDone   out  1      1-cycle pulse at end of each complete frame
//  oFrameCount  out  CNT_W  completed frames, wraps at 2^CNT_W
//  oClipErr     out  1      sticky per frame: pixel seen outside H_ACTIVE x V_ACTIVE
//  oShortErr    out  1      sticky per frame: line or frame shorter than active window
// BEHAVIOUR
//  - reset==0 at posedge clk: every output 0, counters 0, state SYNC. Reset mid-frame
//    discards the frame; no partial frame is ever written after reset.
//  - FSM: SYNC -> (in_fval==0) -> WAIT_FRAME -> (in_fval rising) -> ACTIVE
//    -> (in_fval falling) -> WAIT_FRAME. Edges use a 1-cycle registered copy of the valids.
//  - ACTIVE: x counts in_dval pixels within the line; y counts lines containing >=1 dval.
//    On in_lval falling: x<-0; y<-y+1 if line had pixels; oShortErr<-1 if x<H_ACTIVE.
//  - Write: pixel with in_dval & in_lval in ACTIVE and x<H_ACTIVE, y<V_ACTIVE ->
//    next cycle oWE=1, oX=x, oY=y, oRGB=pixel (latency exactly 1). Otherwise oWE=0;
//    oX/oY/oRGB hold their last values.
//  - Out-of-window pixel: no write, oClipErr<-1. Counters saturate at 1023, no wrap.
//  - in_dval while in_lval==0, or any valid while not ACTIVE: ignored, no write.
//  - in_fval falling: oFrameDone=1 for the next cycle, oFrameCount+=1; oShortErr<-1 if
//    y<V_ACTIVE. Both errors stay valid until in_fval rises, then clear together.
//  - Simultaneous lval and fval falling: line close is processed first, then frame close.
//    Both land in the same cycle.
// CONFIGURATION
//  FB_WR_MIRROR_EN defined: oX = H_ACTIVE-1-x (horizontal mirror for the camera
//    facing the player). Clip/error rules use the unmirrored x.
//  Undefined: oX = x.
// STRUCTURE
//  Package fb_pkg: H_ACTIVE/V_ACTIVE defaults, coord width (10), state enum
//    {SYNC, WAIT_FRAME, ACTIVE}, rgb24 typedef shared with Frame_Buffer.
//  One sub-module, fb_edge_det: registers fval/lval and emits rise/fall strobes.
//  Counters and the FSM stay in the top module.
// TESTING
//  1 reset low during ACTIVE, release mid-frame -> oWE stays 0 until next fval rise;
//    first write is (0,0).
//  2 full 640x480 frame, dval every cycle -> 307200 oWE pulses; last at (639,479);
//    oFrameDone once; oFrameCount=1; no errors.
//  3 line of 650 pixels -> writes x=0..639 only; oClipErr=1 until next fval rise.
//  4 frame of 479 lines, one line of 600 -> oShortErr=1 at frame end; y never exceeds 478.
//  5 dval gaps (every other cycle) plus dval with lval=0 -> 640 writes per line, none
//    outside lval.
//  6 FB_WR_MIRROR_EN defined: first pixel of line -> oX=639; last pixel -> oX=0.
//    FrameCount wraps 65535->0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer write-side types: window defaults, coordinate width, FSM states, pixel struct.
package fb_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CNT_W_DEF    = 16;
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_FRAME,
    ACTIVE
  } fb_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Position counters stop at all-ones so an oversized stream never aliases back into the window.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fb_edge_det.sv
// Registers the frame/line valids once and produces the edge strobes the write FSM acts on.
module fb_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in_fval,
  input  logic in_lval,
  output logic fval_rise,
  output logic fval_fall,
  output logic lval_fall
);

  logic fval_q, fval_d;
  logic lval_q, lval_d;

  always_comb begin
    fval_d = in_fval;
    lval_d = in_lval;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
    end else begin
      fval_q <= fval_d;
      lval_q <= lval_d;
    end
  end

  assign fval_rise = in_fval & ~fval_q;
  assign fval_fall = ~in_fval & fval_q;
  assign lval_fall = ~in_lval & lval_q;

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame_Buffer write-port driver: tracks x/y in the RAW2RGB stream, clips to the window, flags errors.
// Define FB_WR_MIRROR_EN to mirror the written X coordinate horizontally.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_fval,
  input  logic               in_lval,
  input  logic               in_dval,
  input  logic [7:0]         in_red,
  input  logic [7:0]         in_green,
  input  logic [7:0]         in_blue,
  output logic [7:0]         oRed,
  output logic [7:0]         oGreen,
  output logic [7:0]         oBlue,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oWE,
  output logic               oFrameDone,
  output logic [CNT_W-1:0]   oFrameCount,
  output logic               oClipErr,
  output logic               oShortErr
);

  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);

  logic fval_rise, fval_fall, lval_fall;

  fb_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .in_fval  (in_fval),
    .in_lval  (in_lval),
    .fval_rise(fval_rise),
    .fval_fall(fval_fall),
    .lval_fall(lval_fall)
  );

  fb_state_e          state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d;
  logic [COORD_W-1:0] y_line;
  rgb24_t             rgb_q, rgb_d, pix;
  logic               we_q, we_d, done_q, done_d, clip_q, clip_d, short_q, short_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign pix = '{r: in_red, g: in_green, b: in_blue};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    rgb_d   = rgb_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    clip_d  = clip_q;
    short_d = short_q;
    y_line  = y_q;
    case (state_q)
      SYNC: if (!in_fval) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (fval_rise) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          clip_d  = 1'b0;
          short_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (in_dval && in_lval) begin
          if (x_q < H_LIM && y_q < V_LIM) begin
            we_d  = 1'b1;
`ifdef FB_WR_MIRROR_EN
            ox_d  = H_LAST - x_q;
`else
            ox_d  = x_q;
`endif
            oy_d  = y_q;
            rgb_d = pix;
          end else begin
            clip_d = 1'b1;
          end
          x_d = sat_inc(x_q);
        end
        // Line close feeds its updated y into a coincident frame close below.
        if (lval_fall) begin
          x_d = '0;
          if (x_q != '0) y_line = sat_inc(y_q);
          if (x_q < H_LIM) short_d = 1'b1;
          y_d = y_line;
        end
        if (fval_fall) begin
          state_d = WAIT_FRAME;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (y_line < V_LIM) short_d = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SYNC;
      x_q     <= '0;
      y_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      rgb_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      clip_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      rgb_q   <= rgb_d;
      we_q    <= we_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      clip_q  <= clip_d;
      short_q <= short_d;
    end
  end

  assign oRed        = rgb_q.r;
  assign oGreen      = rgb_q.g;
  assign oBlue       = rgb_q.b;
  assign oX          = ox_q;
  assign oY          = oy_q;
  assign oWE         = we_q;
  assign oFrameDone  = done_q;
  assign oFrameCount = cnt_q;
  assign oClipErr    = clip_q;
  assign oShortErr   = short_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Randomized frame-stream bench for fb_write_ctrl on a shrunken 12x6 window with a 4-bit frame counter.
module tb_fb_write_ctrl;

  localparam int H  = 12;
  localparam int V  = 6;
  localparam int CW = 4;
`ifdef FB_WR_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic in_fval = 1'b0, in_lval = 1'b0, in_dval = 1'b0;
  logic [7:0] in_red = '0, in_green = '0, in_blue = '0;
  logic [7:0] oRed, oGreen, oBlue;
  logic [9:0] oX, oY;
  logic oWE, oFrameDone, oClipErr, oShortErr;
  logic [CW-1:0] oFrameCount;

  fb_write_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_fval(in_fval), .in_lval(in_lval), .in_dval(in_dval),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oX(oX), .oY(oY), .oWE(oWE),
    .oFrameDone(oFrameDone), .oFrameCount(oFrameCount), .oClipErr(oClipErr), .oShortErr(oShortErr)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_s = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  typedef struct { int x; int y; logic [23:0] rgb; } wr_t;
  typedef struct { int cnt; bit clip; bit shrt; } done_t;
  typedef struct { bit clip; bit shrt; } err_t;

  // Expectations keyed by the cycle on which they must be visible.
  wr_t   exp_wr[int];
  done_t exp_done[int];
  err_t  exp_err[int];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  int last_x = 0, last_y = 0, m_cnt = 0;
  logic [23:0] last_rgb = '0;
  int obs_n = 0, obs_fx = -1, obs_fy = -1, obs_lx = 0, obs_ly = 0, obs_maxy = 0;
  int d_n = 0, d_fx = 0, d_fy = 0, d_lx = 0, d_ly = 0, d_maxy = 0;

  always @(negedge clk) begin
    if (!rst_s) begin
      chk("rst_we", oWE, 0);
      chk("rst_xy", {oX, oY}, 0);
      chk("rst_rgb", {oRed, oGreen, oBlue}, 0);
      chk("rst_done", oFrameDone, 0);
      chk("rst_cnt", oFrameCount, 0);
      chk("rst_err", {oClipErr, oShortErr}, 0);
      last_x = 0; last_y = 0; last_rgb = '0; m_cnt = 0;
      obs_n = 0; obs_fx = -1; obs_fy = -1; obs_maxy = 0;
    end else begin
      if (exp_wr.exists(cyc)) begin
        chk("we", oWE, 1);
        chk("wr_x", oX, exp_wr[cyc].x);
        chk("wr_y", oY, exp_wr[cyc].y);
        chk("wr_rgb", {oRed, oGreen, oBlue}, exp_wr[cyc].rgb);
        last_x = exp_wr[cyc].x; last_y = exp_wr[cyc].y; last_rgb = exp_wr[cyc].rgb;
      end else begin
        chk("no_we", oWE, 0);
        chk("hold_xy", {oX, oY}, {last_x[9:0], last_y[9:0]});
        chk("hold_rgb", {oRed, oGreen, oBlue}, last_rgb);
      end
      if (oWE === 1'b1) begin
        if (obs_fx < 0) begin obs_fx = int'(oX); obs_fy = int'(oY); end
        obs_lx = int'(oX); obs_ly = int'(oY);
        if (int'(oY) > obs_maxy) obs_maxy = int'(oY);
        obs_n++;
      end
      if (exp_done.exists(cyc)) begin
        chk("done", oFrameDone, 1);
        m_cnt = exp_done[cyc].cnt;
        chk("done_clip", oClipErr, exp_done[cyc].clip);
        chk("done_short", oShortErr, exp_done[cyc].shrt);
        d_n = obs_n; d_fx = obs_fx; d_fy = obs_fy; d_lx = obs_lx; d_ly = obs_ly; d_maxy = obs_maxy;
        obs_n = 0; obs_fx = -1; obs_fy = -1; obs_maxy = 0;
      end else begin
        chk("no_done", oFrameDone, 0);
      end
      chk("frame_cnt", oFrameCount, m_cnt);
      if (exp_err.exists(cyc)) begin
        chk("err_clip", oClipErr, exp_err[cyc].clip);
        chk("err_short", oShortErr, exp_err[cyc].shrt);
      end
    end
  end

  int drv_cnt = 0;

  task automatic drive(input bit f, input bit l, input bit d, input logic [23:0] p);
    in_fval = f; in_lval = l; in_dval = d;
    {in_red, in_green, in_blue} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int nlines, input int base_len, input int odd_line, input int odd_len,
                           input bit gaps, input bit stray, input bit together, input int rst_after);
    int ny = 0;
    bit clip = 0, shrt = 0, sup = 0, lst;
    err_t e;
    e.clip = 0; e.shrt = 0;
    exp_err[cyc + 1] = e;
    drive(1, 0, 0, 24'h0);
    drive(1, 0, 0, 24'h0);
    for (int ln = 0; ln < nlines; ln++) begin
      int len = (ln == odd_line) ? odd_len : base_len;
      int px = 0;
      while (px < len) begin
        bit d = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
        logic [23:0] p = 24'($urandom);
        if (d) begin
          if (!sup) begin
            if (px < H && ny < V) exp_wr[cyc + 1] = '{MIR ? H - 1 - px : px, ny, p};
            else clip = 1;
          end
          px++;
        end
        drive(1, 1, d, p);
      end
      if (px > 0) ny++;
      if (px < H) shrt = 1;
      lst = (ln == nlines - 1);
      if (!(lst && together)) begin
        drive(1, 0, 0, 24'h0);
        if (stray) begin
          drive(1, 0, 1, 24'($urandom));
          drive(1, 0, 1, 24'($urandom));
        end
        if (rst_after == ln) begin
          reset = 1'b0;
          drive(1, 0, 0, 24'h0);
          drive(1, 0, 0, 24'h0);
          reset = 1'b1;
          sup = 1;
          drv_cnt = 0;
        end
        if (!lst) drive(1, 0, 0, 24'h0);
      end
    end
    if (ny < V) shrt = 1;
    if (!sup) begin
      drv_cnt = (drv_cnt + 1) % (1 << CW);
      exp_done[cyc + 1] = '{drv_cnt, clip, shrt};
      e.clip = clip; e.shrt = shrt;
    end
    drive(0, 0, 0, 24'h0);
    for (int g = 0; g < 3; g++) begin
      exp_err[cyc + 1] = e;
      drive(0, 0, stray ? bit'($urandom_range(0, 1)) : 1'b0, 24'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 24'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 24'h123456);

    // Full clean frame.
    run_frame(V, H, -1, 0, 0, 0, 0, -1);
    chk("a_writes", d_n, 72);
    chk("a_last_x", d_lx, MIR ? 0 : 11);
    chk("a_last_y", d_ly, 5);
    chk("a_first_x", d_fx, MIR ? 11 : 0);
    chk("a_count", oFrameCount, 1);
    chk("a_errs", {oClipErr, oShortErr}, 0);

    // Reset between lines mid-frame; the remainder of that frame must produce nothing.
    run_frame(V, H, -1, 0, 0, 0, 0, 1);
    chk("b_count", oFrameCount, 0);
    run_frame(V, H, -1, 0, 0, 0, 0, -1);
    chk("c_first_x", d_fx, MIR ? 11 : 0);
    chk("c_first_y", d_fy, 0);
    chk("c_writes", d_n, 72);
    chk("c_count", oFrameCount, 1);

    // Over-long line clips.
    run_frame(V, H, 2, H + 3, 0, 0, 0, -1);
    chk("d_writes", d_n, 72);
    chk("d_clip", oClipErr, 1);
    chk("d_short", oShortErr, 0);

    // One line short and one line missing.
    run_frame(V - 1, H, 3, 8, 0, 0, 1, -1);
    chk("e_short", oShortErr, 1);
    chk("e_maxy", d_maxy, 4);
    chk("e_writes", d_n, 56);

    // dval gaps and stray dval outside lval.
    run_frame(V, H, -1, 0, 1, 1, 0, -1);
    chk("f_writes", d_n, 72);
    chk("f_errs", {oClipErr, oShortErr}, 0);

    for (int k = 0; k < 14; k++) begin
      int nl = int'($urandom_range(V - 1, V + 1));
      run_frame(nl, int'($urandom_range(H - 2, H + 2)), int'($urandom_range(0, nl)),
                int'($urandom_range(1, H + 3)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), -1);
    end
    chk("wrap_count", oFrameCount, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
